int_calc16: RTL and testbench
=============================

# int_calc16

Single-cycle registered 16-bit signed integer calculator for the norm_logic datapath. Each rising clock edge it applies a 3-bit operation code to the low 16 bits of two 64-bit operand buses. It registers the result onto a 64-bit output bus, sign-extended to the full width. It sits between the operand/opcode source and downstream consumers that read one result per clock.

## Interface
Parameters: none. Width is fixed at 16 computing bits and 64 bus bits.

Ports (reset is synchronous and active-low):
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- operation  input  3  opcode (see Operation).
- opa_calc  input  64  operand A; only bits [15:0] are used, as 16-bit two's complement.
- opb_calc  input  64  operand B; only bits [15:0] are used, as 16-bit two's complement.
- out_calc  output  64  registered result, sign-extended to 64 bits.
- div_err  output  1  registered flag: last op was DIV/MOD with B = 0.

## Operation
- Let a = signed opa_calc[15:0] and b = signed opb_calc[15:0]. Bits [63:16] of both operands are ignored.
- Opcodes:
  - 0 ADD: r = (a + b) mod 2^16, wraps, then sign-extended to 64.
  - 1 SUB: r = (a − b) mod 2^16, wraps, then sign-extended to 64.
  - 2 MUL: full 32-bit signed product a·b, sign-extended to 64. No truncation.
  - 3 DIV: signed quotient, truncated toward zero, 16-bit, sign-extended to 64.
  - 4 MOD: signed remainder. Sign follows the dividend (a = q·b + r). Sign-extended to 64.
  - 5 AND, 6 OR, 7 XOR: bitwise on a and b, 16-bit, sign-extended to 64.
- Divide by zero (op 3 or 4 with b = 0): out_calc = 0, div_err = 1.
- Any other op clears div_err to 0.
- DIV special case −32768 / −1: quotient wraps to −32768 (0xFFFF_FFFF_FFFF_8000). MOD of the same pair = 0. div_err = 0.
- The divider is combinational (no iterative FSM). The full result is ready within the same cycle.
- No handshake. A new operation is accepted every cycle, with no stalls or busy state.

## Timing
- On each rising clk edge:
  - If rst_n = 0: out_calc ← 0 and div_err ← 0. Reset has priority over all inputs.
  - Otherwise out_calc and div_err are loaded from the inputs present at that edge.
- Latency is 1 cycle. Inputs sampled at edge N appear on out_calc immediately after edge N. They hold until edge N+1.
- Throughput is 1 operation per cycle. Back-to-back opcode changes are each reflected on the next edge.
- Reset asserted mid-stream: the next edge zeroes both outputs, and the in-flight operation is discarded. The first result after rst_n rises corresponds to the inputs at the first edge where rst_n = 1.
- Outputs are glitch-free (driven directly from flops). Inputs must meet setup/hold to clk.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with nonzero inputs -> out_calc = 0, div_err = 0. Release rst_n, then op=0, A=25, B=30 -> after 1 edge out_calc = 55.
- SUB both signs: op=1, A=25, B=30 -> 0xFFFF_FFFF_FFFF_FFFB (−5). Then op=1, A=20, B=5 -> 15 on the following edge.
- MUL/DIV/MOD: op=2, A=4, B=5 -> 20. op=3, A=10, B=2 -> 5. op=4, A=10, B=2 -> 0. Also op=3, A=−7, B=2 -> −3, and op=4, same operands -> −1.
- Divide by zero: op=3, A=10, B=0 -> out_calc = 0, div_err = 1. Next op=0, A=1, B=1 -> 2, div_err = 0.
- Wrap and width rules:
  - op=0, A=0x7FFF, B=1 -> 0xFFFF_FFFF_FFFF_8000.
  - op=2, A=0x7FFF, B=0x7FFF -> 0x3FFF_0001.
  - op=0, A=0xABCD_0000_0000_0003, B=4 -> 7 (upper operand bits ignored).
- Bitwise and reset mid-stream: op=5/6/7, A=0x00F0, B=0x0FF0 -> 0xF0 / 0xFF0 / 0xF00. Assert rst_n = 0 during a run of ops -> 0 on the next edge.

Source files
------------

// File: rtl/int_calc16.sv
// int_calc16: registered 16-bit signed calculator with 64-bit sign-extended result and divide-by-zero flag
module int_calc16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  operation,
  input  logic [63:0] opa_calc,
  input  logic [63:0] opb_calc,
  output logic [63:0] out_calc,
  output logic        div_err
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  logic signed [15:0] w_a;
  logic signed [15:0] w_b;
  logic signed [16:0] w_a17;
  logic signed [16:0] w_b17;
  logic signed [16:0] w_q;
  logic signed [16:0] w_r;
  logic signed [31:0] w_prod;
  logic        [15:0] w_res16;
  logic               w_bz;
  logic               w_is_div;
  logic        [63:0] w_next;
  logic        [63:0] r_out;
  logic               r_err;
  assign w_a      = opa_calc[15:0];
  assign w_b      = opb_calc[15:0];
  assign w_bz     = (w_b == 16'sd0);
  assign w_is_div = (operation == OP_DIV) || (operation == OP_MOD);
  // 17-bit division so -32768 / -1 yields +32768, which truncates back to 0x8000
  assign w_a17    = 17'(w_a);
  assign w_b17    = 17'(w_b);
  assign w_q      = w_bz ? 17'sd0 : w_a17 / w_b17;
  assign w_r      = w_bz ? 17'sd0 : w_a17 % w_b17;
  assign w_prod   = 32'(w_a) * 32'(w_b);
  // select the 16-bit result, then widen; MUL keeps its full 32-bit product
  always_comb begin
    w_res16 = operation == OP_ADD ? 16'(w_a + w_b) :
              operation == OP_SUB ? 16'(w_a - w_b) :
              operation == OP_DIV ? w_q[15:0] :
              operation == OP_MOD ? w_r[15:0] :
              operation == OP_AND ? (w_a & w_b) :
              operation == OP_OR  ? (w_a | w_b) : (w_a ^ w_b);
    w_next  = (w_is_div && w_bz) ? 64'd0 :
              operation == OP_MUL ? {{32{w_prod[31]}}, w_prod} : {{48{w_res16[15]}}, w_res16};
  end
  // result and error flag registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= 64'd0;
      r_err <= 1'b0;
    end else begin
      r_out <= w_next;
      r_err <= w_is_div && w_bz;
    end
  end
  assign out_calc = r_out;
  assign div_err  = r_err;
endmodule

// File: tb/tb_int_calc16.sv
// tb_int_calc16: directed-vector self-checking bench for int_calc16
module tb_int_calc16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  operation = 3'd0;
  logic [63:0] opa_calc = 64'd0;
  logic [63:0] opb_calc = 64'd0;
  logic [63:0] out_calc;
  logic        div_err;
  int checks = 0;
  int errors = 0;
  int_calc16 dut (
    .clk(clk),
    .rst_n(rst_n),
    .operation(operation),
    .opa_calc(opa_calc),
    .opb_calc(opb_calc),
    .out_calc(out_calc),
    .div_err(div_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // drive one operation, clock it in, sample 1 time unit after the edge
  task automatic step(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    operation = op;
    opa_calc  = a;
    opb_calc  = b;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input logic exp_err);
    step(op, a, b);
    chk({tag, "_out"}, out_calc, exp);
    chk({tag, "_err"}, {63'd0, div_err}, {63'd0, exp_err});
  endtask
  initial begin
    rst_n = 1'b0;
    step(3'd3, 64'd10, 64'd0);
    step(3'd2, 64'd7, 64'd9);
    chk("rst_out", out_calc, 64'd0);
    chk("rst_err", {63'd0, div_err}, 64'd0);
    rst_n = 1'b1;
    run("add", 3'd0, 64'd25, 64'd30, 64'd55, 1'b0);
    run("sub_neg", 3'd1, 64'd25, 64'd30, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
    run("sub_pos", 3'd1, 64'd20, 64'd5, 64'd15, 1'b0);
    run("mul", 3'd2, 64'd4, 64'd5, 64'd20, 1'b0);
    run("div", 3'd3, 64'd10, 64'd2, 64'd5, 1'b0);
    run("mod", 3'd4, 64'd10, 64'd2, 64'd0, 1'b0);
    run("div_neg", 3'd3, 64'hFFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run("mod_neg", 3'd4, 64'hFFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run("mod_pos_negb", 3'd4, 64'd7, 64'hFFFE, 64'd1, 1'b0);
    run("div0", 3'd3, 64'd10, 64'd0, 64'd0, 1'b1);
    run("add_clr", 3'd0, 64'd1, 64'd1, 64'd2, 1'b0);
    run("mod0", 3'd4, 64'd10, 64'hFFFF_0000_0000_0000, 64'd0, 1'b1);
    run("add_wrap", 3'd0, 64'h7FFF, 64'd1, 64'hFFFF_FFFF_FFFF_8000, 1'b0);
    run("sub_wrap", 3'd1, 64'h8000, 64'd1, 64'h7FFF, 1'b0);
    run("mul_max", 3'd2, 64'h7FFF, 64'h7FFF, 64'h3FFF_0001, 1'b0);
    run("mul_min", 3'd2, 64'h8000, 64'h8000, 64'h4000_0000, 1'b0);
    run("mul_neg", 3'd2, 64'hFFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run("add_hi", 3'd0, 64'hABCD_0000_0000_0003, 64'd4, 64'd7, 1'b0);
    run("div_ovf", 3'd3, 64'h8000, 64'hFFFF, 64'hFFFF_FFFF_FFFF_8000, 1'b0);
    run("mod_ovf", 3'd4, 64'h8000, 64'hFFFF, 64'd0, 1'b0);
    run("and", 3'd5, 64'h00F0, 64'h0FF0, 64'hF0, 1'b0);
    run("or", 3'd6, 64'h00F0, 64'h0FF0, 64'hFF0, 1'b0);
    run("xor", 3'd7, 64'h00F0, 64'h0FF0, 64'hF00, 1'b0);
    run("xor_sx", 3'd7, 64'h8000, 64'h0001, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    run("div0_pre", 3'd3, 64'd5, 64'd0, 64'd0, 1'b1);
    rst_n = 1'b0;
    run("mid_rst", 3'd0, 64'd100, 64'd200, 64'd0, 1'b0);
    rst_n = 1'b1;
    run("post_rst", 3'd2, 64'd6, 64'd7, 64'd42, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
